// File: rtl/seven_seg_scan_mux_if.sv
// Bus between the scan multiplexer and its client: per-digit patterns in, shared
// segment bus, digit selects and frame pulse out.
interface seven_seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic [7*NUM_DIGITS-1:0]   seg_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic [6:0]                seg;
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     dig_n;
    logic                      frame_tick;

    modport master (
        output en, seg_in, dp_in, blink_mask,
        input  seg, dp_n, dig_n, frame_tick
    );

    modport slave (
        input  en, seg_in, dp_in, blink_mask,
        output seg, dp_n, dig_n, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan_mux.sv
// Frame-latched, blank-gapped multiplexer for an active-low 7-segment display.
// Optional digit blinking is compiled in with BLINK_EN.
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_TICKS  = 27000,
    parameter int BLANK_TICKS  = 270,
    parameter int DIG_ACT_LOW  = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    seven_seg_scan_mux_if.slave  bus
);
    localparam int CNT_W = $clog2(DIGIT_TICKS);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_TICKS);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = (DIG_ACT_LOW != 0) ? '1 : '0;

    typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [7*NUM_DIGITS-1:0] snap;
    logic [NUM_DIGITS-1:0]   dp_snap;
    logic [6:0]              seg_r;
    logic                    dp_n_r;
    logic [NUM_DIGITS-1:0]   dig_n_r;
    logic                    frame_tick_r;

    phase_t                  phase;
    logic                    frame_start;
    logic                    hide;
    logic                    show;
    logic [NUM_DIGITS-1:0]   sel;
    logic [NUM_DIGITS-1:0]   dig_on;

`ifdef BLINK_EN
    localparam int BF_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES);

    logic            blink_phase;
    logic [BF_W-1:0] blink_cnt;

    // Counter holds ticks seen in the current half-period, so the toggle lands on
    // the frame start that begins the next half-period.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
        end else if (bus.en && frame_start) begin
            if (blink_cnt == BF_LAST) begin
                blink_phase <= ~blink_phase;
                blink_cnt   <= BF_W'(1);
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb hide = blink_phase & bus.blink_mask[idx];
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^bus.blink_mask;
    assign hide = 1'b0;
`endif

    always_comb begin
        phase       = (cnt < CNT_BLANK) ? PH_BLANK : PH_SHOW;
        frame_start = (cnt == '0) && (idx == '0);
        show        = (phase == PH_SHOW) && !hide;
        sel         = '0;
        sel[idx]    = 1'b1;
        dig_on      = (DIG_ACT_LOW != 0) ? ~sel : sel;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt          <= '0;
            idx          <= '0;
            snap         <= '1;
            dp_snap      <= '0;
            seg_r        <= 7'h7F;
            dp_n_r       <= 1'b1;
            dig_n_r      <= DIG_OFF;
            frame_tick_r <= 1'b0;
        end else if (!bus.en) begin
            cnt          <= '0;
            idx          <= '0;
            seg_r        <= 7'h7F;
            dp_n_r       <= 1'b1;
            dig_n_r      <= DIG_OFF;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= frame_start;
            if (frame_start) begin
                snap    <= bus.seg_in;
                dp_snap <= bus.dp_in;
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (show) begin
                seg_r   <= snap[7*idx +: 7];
                dp_n_r  <= ~dp_snap[idx];
                dig_n_r <= dig_on;
            end else begin
                seg_r   <= 7'h7F;
                dp_n_r  <= 1'b1;
                dig_n_r <= DIG_OFF;
            end
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dp_n       = dp_n_r;
    assign bus.dig_n      = dig_n_r;
    assign bus.frame_tick = frame_tick_r;
endmodule
